instr_encoder: RTL and testbench

Instruction encoder for the simple CPU: accepts decoded instruction fields (the same field set `cpu_control` produces) over a valid/ready handshake and emits packed 32-bit instruction words with sequential program addresses for loading into instruction memory. It is the inverse of the decoder and sits between the test/program-loader front end and the instruction-memory write port. A 2-entry output buffer gives full throughput under backpressure.

---
 rtl/cpu_isa_pkg.sv | 32 +++
 rtl/instr_fifo2.sv | 71 +++++++
 rtl/instr_encoder.sv | 106 ++++++++++
 tb/tb_instr_encoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the simple CPU: opcodes, field positions, instruction kinds
// and the encoder's output-buffer occupancy states.
package cpu_isa_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_BNE   = 6'b000101;

  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;

  typedef enum logic [1:0] {
    KIND_R   = 2'd0,
    KIND_J   = 2'd1,
    KIND_BNE = 2'd2,
    KIND_I   = 2'd3
  } instr_kind_e;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_e;

  // Opcodes that an I-type word must not carry, since they select another format.
  function automatic logic is_reserved_opc(input logic [5:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_J) || (opc == OPC_BNE);
  endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry FIFO with valid/ready on both sides and a synchronous clear.
// Occupancy FSM state is exposed on state_dbg.
module instr_fifo2
  import cpu_isa_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output fifo_state_e  state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the sender holds data stable while valid && !ready. Ready depends only on state.
  fifo_state_e state, state_nx;
  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic         push, pop;

  assign in_ready  = (state != FIFO_FULL);
  assign out_valid = (state != FIFO_EMPTY);
  assign push      = in_valid && in_ready && !clear;
  assign pop       = out_valid && out_ready && !clear;
  assign out_data  = mem[rd_ptr];
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FIFO_EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FIFO_EMPTY: if (push) state_nx = FIFO_ONE;
      FIFO_ONE: begin
        if (push && !pop)      state_nx = FIFO_FULL;
        else if (pop && !push) state_nx = FIFO_EMPTY;
      end
      FIFO_FULL:  if (pop) state_nx = FIFO_ONE;
      default:    state_nx = FIFO_EMPTY;
    endcase
    if (clear) state_nx = FIFO_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 32-bit words tagged with sequential program addresses.
// Define INSTR_ENCODER_CHECK_EN to flag out-of-range fields on out_err.
module instr_encoder
  import cpu_isa_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_src_reg1,
  input  logic [5:0]        in_src_reg2,
  input  logic [5:0]        in_dst_reg,
  input  logic [15:0]       in_immediate,
  input  logic [31:0]       in_jump_address,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  localparam int FW = 32 + ADDR_W + 1;

  logic [31:0]       word_c;
  logic              err_c;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic [FW-1:0]     fifo_out;
  fifo_state_e       fifo_state;

  assign accept = in_valid && in_ready && !clear;

  always_comb begin
    word_c = '0;
    case (instr_kind_e'(in_kind))
      KIND_R: begin
        word_c[OPC_LSB +: 6] = OPC_RTYPE;
        word_c[RS_LSB  +: 5] = in_src_reg1[4:0];
        word_c[RT_LSB  +: 5] = in_src_reg2[4:0];
        word_c[RD_LSB  +: 5] = in_dst_reg[4:0];
      end
      KIND_J: word_c = {OPC_J, in_jump_address[25:0]};
      KIND_BNE: begin
        word_c[OPC_LSB +: 6] = OPC_BNE;
        word_c[RS_LSB  +: 5] = in_src_reg1[4:0];
        word_c[RT_LSB  +: 5] = in_src_reg2[4:0];
        word_c[15:0]         = in_immediate;
      end
      default: begin
        word_c[OPC_LSB +: 6] = in_opcode;
        word_c[RS_LSB  +: 5] = in_src_reg1[4:0];
        word_c[RT_LSB  +: 5] = in_dst_reg[4:0];
        word_c[15:0]         = in_immediate;
      end
    endcase
  end

`ifdef INSTR_ENCODER_CHECK_EN
  always_comb begin
    err_c = 1'b0;
    case (instr_kind_e'(in_kind))
      KIND_R:   err_c = in_src_reg1[5] | in_src_reg2[5] | in_dst_reg[5];
      KIND_J:   err_c = |in_jump_address[31:26];
      KIND_BNE: err_c = in_src_reg1[5] | in_src_reg2[5];
      default:  err_c = in_src_reg1[5] | in_dst_reg[5] | is_reserved_opc(in_opcode);
    endcase
  end
`else
  // Truncated bits are deliberately dropped in this build.
  logic unused_fields;
  assign unused_fields = ^{in_jump_address[31:26], in_src_reg1[5], in_src_reg2[5], in_dst_reg[5]};
  assign err_c = 1'b0;
`endif

  // Counter wraps through zero; only clear and reset return it to BASE_ADDR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      addr <= BASE_ADDR;
    else if (clear)  addr <= BASE_ADDR;
    else if (accept) addr <= addr + ADDR_W'(1);
  end

  instr_fifo2 #(.W(FW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({word_c, addr, err_c}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (fifo_out),
    .state_dbg (fifo_state)
  );

  logic unused_dbg;
  assign unused_dbg = ^fifo_state;

  assign {out_word, out_addr, out_err} = fifo_out;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, scoreboard queue, negedge monitor.
module tb_instr_encoder;

  localparam int AW = 4;
  localparam int RW = 32 + AW + 1;
`ifdef INSTR_ENCODER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [1:0] K_R = 2'd0, K_J = 2'd1, K_B = 2'd2, K_I = 2'd3;

  logic          clk, rst_n, clear;
  logic          in_valid, in_ready;
  logic [1:0]    in_kind;
  logic [5:0]    in_opcode, in_src_reg1, in_src_reg2, in_dst_reg;
  logic [15:0]   in_immediate;
  logic [31:0]   in_jump_address;
  logic          out_valid, out_ready;
  logic [31:0]   out_word;
  logic [AW-1:0] out_addr;
  logic          out_err;

  logic [RW-1:0] exp_q[$];
  logic [AW-1:0] addr_m;
  int            n_checks, n_fail;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR('0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (clear),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_kind         (in_kind),
    .in_opcode       (in_opcode),
    .in_src_reg1     (in_src_reg1),
    .in_src_reg2     (in_src_reg2),
    .in_dst_reg      (in_dst_reg),
    .in_immediate    (in_immediate),
    .in_jump_address (in_jump_address),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_word        (out_word),
    .out_addr        (out_addr),
    .out_err         (out_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Driver: called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] kind, input logic [5:0] opc, input logic [5:0] rs,
                      input logic [5:0] rt, input logic [5:0] rd, input logic [15:0] imm,
                      input logic [31:0] ja, input logic [31:0] exp_word, input bit exp_err,
                      input bit track);
    int waited;
    in_kind = kind; in_opcode = opc; in_src_reg1 = rs; in_src_reg2 = rt;
    in_dst_reg = rd; in_immediate = imm; in_jump_address = ja;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      step(1);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", waited);
      in_valid = 1'b0;
      return;
    end
    if (track) exp_q.push_back({exp_word, addr_m, exp_err});
    addr_m = addr_m + 1'b1;
    step(1);
    in_valid = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got word 0x%0h addr %0d with empty queue", out_word, out_addr);
      end else begin
        check("out_rec", {out_word, out_addr, out_err}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int waited;
    n_checks = 0; n_fail = 0; addr_m = '0;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_kind = '0; in_opcode = '0; in_src_reg1 = '0; in_src_reg2 = '0;
    in_dst_reg = '0; in_immediate = '0; in_jump_address = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_word", out_word, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_err", out_err, 0);
    step(1);
    out_ready = 1'b1;

    // R-type, single-cycle latency
    send(K_R, 6'h00, 6'd1, 6'd2, 6'd3, 16'h0, 32'h0, 32'h00221800, 1'b0, 1'b1);
    check("latency_valid", out_valid, 1);
    step(2);

    // Mixed back-to-back stream
    send(K_J, 6'h00, 6'd0, 6'd0, 6'd0, 16'h0, 32'h40, 32'h08000040, 1'b0, 1'b1);
    send(K_B, 6'h00, 6'd4, 6'd5, 6'd0, 16'hFFFC, 32'h0, 32'h1485FFFC, 1'b0, 1'b1);
    send(K_I, 6'h08, 6'd0, 6'd0, 6'd9, 16'h0010, 32'h0, 32'h20090010, 1'b0, 1'b1);
    step(3);

    // Backpressure
    out_ready = 1'b0;
    send(K_R, 6'h00, 6'd7, 6'd8, 6'd9, 16'h0, 32'h0, 32'h00E84800, 1'b0, 1'b1);
    send(K_J, 6'h00, 6'd0, 6'd0, 6'd0, 16'h0, 32'h03FFFFFF, 32'h0BFFFFFF, 1'b0, 1'b1);
    check("bp_in_ready", in_ready, 0);
    check("bp_hold_word", out_word, 32'h00E84800);
    step(2);
    check("bp_hold_word2", out_word, 32'h00E84800);
    check("bp_hold_addr", out_addr, 4);
    fork
      send(K_B, 6'h00, 6'd31, 6'd0, 6'd0, 16'h1234, 32'h0, 32'h17E01234, 1'b0, 1'b1);
      begin
        step(3);
        out_ready = 1'b1;
      end
    join
    step(4);

    // Clear while FULL with a concurrent input
    out_ready = 1'b0;
    send(K_R, 6'h00, 6'd1, 6'd1, 6'd1, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    send(K_R, 6'h00, 6'd2, 6'd2, 6'd2, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("full_in_ready", in_ready, 0);
    clear = 1'b1;
    in_valid = 1'b1;
    in_kind = K_J;
    step(1);
    clear = 1'b0;
    in_valid = 1'b0;
    addr_m = '0;
    check("clr_out_valid", out_valid, 0);
    check("clr_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send(K_I, 6'h0F, 6'd2, 6'd0, 6'd3, 16'hABCD, 32'h0, 32'h3C43ABCD, 1'b0, 1'b1);
    step(3);

    // Address wrap: 17 words after clear -> 0..15 then 0
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    addr_m = '0;
    for (int i = 0; i < 17; i++) begin
      send(K_I, 6'h08, 6'd1, 6'd0, 6'(i), 16'(i), 32'h0,
           {6'h08, 5'd1, 5'(i), 16'(i)}, 1'b0, 1'b1);
    end
    step(3);

    // Range violations (flagged only with the check build)
    send(K_R, 6'h00, 6'd0, 6'd0, 6'd33, 16'h0, 32'h0, 32'h00000800, CHK, 1'b1);
    send(K_J, 6'h00, 6'd0, 6'd0, 6'd0, 16'h0, 32'h04000040, 32'h08000040, CHK, 1'b1);
    send(K_I, 6'h00, 6'd1, 6'd0, 6'd2, 16'h0005, 32'h0, 32'h00220005, CHK, 1'b1);
    send(K_B, 6'h00, 6'd36, 6'd1, 6'd0, 16'h0000, 32'h0, 32'h14810000, CHK, 1'b1);
    send(K_I, 6'h08, 6'd1, 6'd63, 6'd2, 16'h0000, 32'h0, 32'h20220000, 1'b0, 1'b1);

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      step(1);
      waited++;
    end
    check("drain", exp_q.size(), 0);

    // Asynchronous reset drops buffered words
    out_ready = 1'b0;
    send(K_R, 6'h00, 6'd3, 6'd3, 6'd3, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_ready", in_ready, 1);
    check("async_rst_word", out_word, 0);
    step(1);
    rst_n = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
